// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-size limits.
// Used by uart_rx and uart_baud_tick (and the future transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int STOP_BITS_MAX = 2;
    localparam int DATA_BITS_MAX = 9;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-cycle tick every CLK_DIV clocks, realignable
// to the current cycle through restart.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with mid-bit start validation, valid/ready output
// and per-word error flags. Optional parity checking under UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 27,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;
    logic                   tick;
    logic                   restart;
    logic                   commit;

    rx_state_t              state_reg, state_next;
    logic [TICK_W-1:0]      tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   ferr_reg, ferr_next;
    logic                   armed_reg, armed_next;
`ifdef UART_RX_PARITY_EN
    logic                   perr_reg, perr_next;
    logic                   parity_err_reg;
`endif

    logic [DATA_BITS-1:0]   rx_data_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;

    // Synchroniser resets to the idle level so reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ferr_reg     <= 1'b0;
            armed_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            ferr_reg     <= ferr_next;
            armed_reg    <= armed_next;
`ifdef UART_RX_PARITY_EN
            perr_reg     <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        ferr_next     = ferr_reg;
        armed_next    = armed_reg;
        restart       = 1'b0;
        commit        = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next     = perr_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Only re-arm after seeing idle-high, so a held break is one word.
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                    restart       = 1'b1;
                    armed_next    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_MID) begin
                        tick_cnt_next = '0;
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                            ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
                            perr_next    = 1'b0;
`endif
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                            state_next   = PARITY;
`else
                            state_next   = STOP;
`endif
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        perr_next     = (^shift_reg) ^ rx_s ^ 1'(PARITY_ODD);
                        state_next    = STOP;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        ferr_next     = ferr_reg | ~rx_s;
                        // Leave at the centre of the last stop bit to resync early.
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_next = '0;
                            commit       = 1'b1;
                            state_next   = IDLE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output holding register; an accept coinciding with a commit is a clean handover.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (commit) begin
            rx_data_reg    <= shift_reg;
            rx_valid_reg   <= 1'b1;
            frame_err_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= perr_reg;
`endif
            if (rx_valid_reg && !rx_ready) begin
                overrun_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                overrun_reg <= 1'b0;
            end
        end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule
